// File: rtl/des_round_iterator.sv
// des_round_iterator: iterative DES Feistel core, one round per clk, external combinational f-function loop.
// Latency: Start sampled at E0, rounds written E1..E16, Swap_Select high E16..E17; one block per 18 cycles.
// Backpressure: none; Start is ignored while Busy. Optional Abort input when DES_ABORT_EN is defined.
module des_round_iterator #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Decrypt,
    input  logic [31:0] Input_Left,
    input  logic [31:0] Input_Right,
    output logic [31:0] F_Right,
    output logic [3:0]  Key_Index,
    input  logic [31:0] F_Result,
`ifdef DES_ABORT_EN
    input  logic        Abort,
`endif
    output logic        Busy,
    output logic [31:0] Output_Left,
    output logic [31:0] Output_Right,
    output logic        Swap_Select
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_l;
    logic [31:0]      r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dec;
    logic             w_load;
    logic             w_round;
    logic             w_clear;
    logic             w_abort;
    logic             w_last;

`ifdef DES_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(NUM_ROUNDS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, datapath strobes and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_round     = 1'b0;
        w_clear     = 1'b0;
        Busy        = 1'b0;
        Swap_Select = 1'b0;
        Key_Index   = 4'd0;
        case (r_state)
            S_IDLE: begin
                // Abort in IDLE only blocks a simultaneous Start
                if (Start && !w_abort) begin
                    w_state_nxt = S_ROUND;
                    w_load      = 1'b1;
                end
            end
            S_ROUND: begin
                Busy    = 1'b1;
                w_round = 1'b1;
                // Encrypt walks keys 0..N-1, decrypt walks them backwards
                Key_Index = r_dec ? 4'(CNT_W'(NUM_ROUNDS) - r_cnt)
                                  : 4'(r_cnt - CNT_W'(1));
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Busy        = 1'b1;
                Swap_Select = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort wins over any round work; the DONE pulse itself is combinational and still shows
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_round     = 1'b0;
            w_clear     = 1'b1;
        end
    end

    // Feistel datapath: load halves, then L<=R, R<=L^f(R,K) each round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l   <= 32'd0;
            r_r   <= 32'd0;
            r_cnt <= '0;
            r_dec <= 1'b0;
        end else if (w_clear) begin
            r_l   <= 32'd0;
            r_r   <= 32'd0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_l   <= Input_Left;
            r_r   <= Input_Right;
            r_cnt <= CNT_W'(1);
            r_dec <= Decrypt;
        end else if (w_round) begin
            r_l <= r_r;
            r_r <= r_l ^ F_Result;
            // Counter parks at NUM_ROUNDS on the last round rather than wrapping
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign F_Right      = r_r;
    assign Output_Left  = r_l;
    assign Output_Right = r_r;

endmodule

// File: tb/tb_des_round_iterator.sv
// tb_des_round_iterator: drives des_round_iterator with a behavioural DES f-function and key schedule.
// Expected results come from a plain 16-round Feistel loop over the same f-function.
// Directed known-answer vectors, random blocks, reset and (optionally) abort scenarios.
module tb_des_round_iterator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        Start = 1'b0;
    logic        Decrypt = 1'b0;
    logic [31:0] Input_Left = 32'd0;
    logic [31:0] Input_Right = 32'd0;
    logic [31:0] F_Right;
    logic [3:0]  Key_Index;
    logic [31:0] F_Result;
    logic        Busy;
    logic [31:0] Output_Left;
    logic [31:0] Output_Right;
    logic        Swap_Select;
`ifdef DES_ABORT_EN
    logic        Abort = 1'b0;
`endif

    int   checks = 0;
    int   failures = 0;
    logic zero_f = 1'b0;
    logic [47:0] ks [16];

    int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    always #5 clk = ~clk;

    // DES f-function: expansion, key mix, S-boxes, P permutation (bit 1 = MSB)
    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s_out;
        logic [31:0] p_out;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int s = 0; s < 8; s++) begin
            six = x[47-6*s -: 6];
            idx = int'({six[5], six[0], six[4:1]});
            s_out[31-4*s -: 4] = SBOX[s][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) p_out[31-i] = s_out[32-P_T[i]];
        return p_out;
    endfunction

    task automatic make_keys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < SH_T[r]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2_T[i]];
        end
    endtask

    // Reference: sixteen Feistel rounds with forward or reversed key order
    function automatic logic [63:0] ref_block(input logic [31:0] l0, input logic [31:0] r0,
                                              input logic dec, input logic zf);
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        l = l0;
        r = r0;
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ (zf ? 32'd0 : des_f(r, ks[dec ? 15 - i : i]));
            l = t;
        end
        return {l, r};
    endfunction

    assign F_Result = zero_f ? 32'd0 : des_f(F_Right, ks[Key_Index]);

    des_round_iterator #(.NUM_ROUNDS(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Start        (Start),
        .Decrypt      (Decrypt),
        .Input_Left   (Input_Left),
        .Input_Right  (Input_Right),
        .F_Right      (F_Right),
        .Key_Index    (Key_Index),
        .F_Result     (F_Result),
`ifdef DES_ABORT_EN
        .Abort        (Abort),
`endif
        .Busy         (Busy),
        .Output_Left  (Output_Left),
        .Output_Right (Output_Right),
        .Swap_Select  (Swap_Select)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_swap"}, 64'(Swap_Select), 64'd0);
        check({tag, "_kidx"}, 64'(Key_Index), 64'd0);
        check({tag, "_fr"}, 64'(F_Right), 64'd0);
        check({tag, "_ol"}, 64'(Output_Left), 64'd0);
        check({tag, "_or"}, 64'(Output_Right), 64'd0);
    endtask

    // Issue Start and follow the run to completion, checking every round
    task automatic run_block(input logic [31:0] l0, input logic [31:0] r0,
                             input logic dec, input logic noisy);
        logic [63:0] exp;
        logic [31:0] ml;
        logic [31:0] mr;
        logic [31:0] t;
        int          k;
        exp = ref_block(l0, r0, dec, zero_f);
        Input_Left  = l0;
        Input_Right = r0;
        Decrypt     = dec;
        Start       = 1'b1;
        @(posedge clk); #1;
        Start       = 1'b0;
        Input_Left  = $urandom;
        Input_Right = $urandom;
        Decrypt     = 1'($urandom);
        ml = l0;
        mr = r0;
        for (int i = 0; i < 16; i++) begin
            k = dec ? 15 - i : i;
            check("key_index", 64'(Key_Index), 64'(k));
            check("f_right", 64'(F_Right), 64'(mr));
            check("busy_round", 64'(Busy), 64'd1);
            check("swap_early", 64'(Swap_Select), 64'd0);
            if (noisy) begin
                Start      = 1'($urandom);
                Decrypt    = 1'($urandom);
                Input_Left = $urandom;
            end
            t  = mr;
            mr = ml ^ (zero_f ? 32'd0 : des_f(mr, ks[k]));
            ml = t;
            @(posedge clk); #1;
        end
        Start = 1'b0;
        check("swap_pulse", 64'(Swap_Select), 64'd1);
        check("busy_done", 64'(Busy), 64'd1);
        check("kidx_done", 64'(Key_Index), 64'd0);
        check("out_left", 64'(Output_Left), 64'(exp[63:32]));
        check("out_right", 64'(Output_Right), 64'(exp[31:0]));
        @(posedge clk); #1;
        check("swap_end", 64'(Swap_Select), 64'd0);
        check("busy_idle", 64'(Busy), 64'd0);
        check("hold_left", 64'(Output_Left), 64'(exp[63:32]));
        check("hold_right", 64'(Output_Right), 64'(exp[31:0]));
    endtask

    initial begin
        logic [31:0] rl;
        logic [31:0] rr;
        logic [31:0] cl;
        logic [31:0] cr;
        logic        seen;

        make_keys(64'h133457799BBCDFF1);

        // Asynchronous reset mid-cycle, then a quiet idle stretch
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_swap", 64'(Swap_Select), 64'd0);
            check("idle_busy", 64'(Busy), 64'd0);
        end

        // Known-answer encrypt
        run_block(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1'b0);
        check("kat_enc_l", 64'(Output_Left), 64'h43423234);
        check("kat_enc_r", 64'(Output_Right), 64'h0A4CD995);

        // Known-answer decrypt of the swapped ciphertext halves
        run_block(32'h0A4CD995, 32'h43423234, 1'b1, 1'b0);
        check("kat_dec_l", 64'(Output_Left), 64'hF0AAF0AA);
        check("kat_dec_r", 64'(Output_Right), 64'hCC00CCFF);

        // Zero f-function: an even number of plain swaps returns the input, Start noise ignored
        zero_f = 1'b1;
        run_block(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
        check("triv_l", 64'(Output_Left), 64'h12345678);
        check("triv_r", 64'(Output_Right), 64'h9ABCDEF0);
        zero_f = 1'b0;

        // Random blocks with busy-time input noise, and encrypt/decrypt round trips
        for (int n = 0; n < 4; n++) begin
            run_block($urandom, $urandom, 1'($urandom), 1'b1);
        end
        for (int n = 0; n < 3; n++) begin
            rl = $urandom;
            rr = $urandom;
            run_block(rl, rr, 1'b0, 1'b1);
            cl = Output_Left;
            cr = Output_Right;
            run_block(cr, cl, 1'b1, 1'b1);
            check("rt_l", 64'(Output_Left), 64'(rr));
            check("rt_r", 64'(Output_Right), 64'(rl));
        end

        // Reset in the middle of a run discards the block
        Input_Left  = $urandom;
        Input_Right = $urandom;
        Start       = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before", 64'(Busy), 64'd1);
        rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (Swap_Select) seen = 1'b1;
        end
        check("mid_no_swap", 64'(seen), 64'd0);
        check("mid_idle_busy", 64'(Busy), 64'd0);
        run_block($urandom, $urandom, 1'b0, 1'b0);

`ifdef DES_ABORT_EN
        // Abort during round 5
        Input_Left  = $urandom;
        Input_Right = $urandom;
        Start       = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        check_all_zero("abort");
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (Swap_Select || Busy) seen = 1'b1;
        end
        check("abort_quiet", 64'(seen), 64'd0);

        // Abort and Start together in IDLE: Start is not taken
        Input_Left  = 32'hDEADBEEF;
        Input_Right = 32'h01234567;
        Start       = 1'b1;
        Abort       = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        Abort = 1'b0;
        check("abort_start_busy", 64'(Busy), 64'd0);
        check("abort_start_ol", 64'(Output_Left), 64'd0);
        run_block($urandom, $urandom, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
